// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_pkg
// Brief    : Shared constants, FSM state type and helpers for the multdiv unit.
// Revision : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = 32;
    localparam int CNT_W    = 6;

    localparam logic [MD_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Magnitude of a two's complement value; INT_MIN maps to 0x80000000 as unsigned.
    function automatic logic [MD_WIDTH-1:0] abs_val(input logic [MD_WIDTH-1:0] v);
        return v[MD_WIDTH-1] ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_div_step.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_div_step
// Brief    : One combinational restoring-division step (shift, trial subtract).
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_div_step
    import multdiv_pkg::*;
(
    input  logic [MD_WIDTH:0]   rem_i,
    input  logic [MD_WIDTH-1:0] quo_i,
    input  logic [MD_WIDTH-1:0] divisor_i,
    output logic [MD_WIDTH:0]   rem_o,
    output logic [MD_WIDTH-1:0] quo_o
);

    logic [MD_WIDTH+1:0] w_shift;
    logic [MD_WIDTH+1:0] w_diff;
    logic                w_fits;

    // Extra top bit turns the trial subtraction borrow into a sign test.
    assign w_shift = {rem_i, quo_i[MD_WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, divisor_i};
    assign w_fits  = ~w_diff[MD_WIDTH+1];

    assign rem_o = w_fits ? w_diff[MD_WIDTH:0] : w_shift[MD_WIDTH:0];
    assign quo_o = {quo_i[MD_WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_unit
// Brief    : Iterative signed 32-bit multiply/divide with one-cycle ready pulse.
// Config   : MULTDIV_DBZ_FAST_EN - divide by zero bypasses the iterations.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [MD_WIDTH-1:0] data_operandA,
    input  logic [MD_WIDTH-1:0] data_operandB,
    input  logic                ctrl_mult,
    input  logic                ctrl_div,
    output logic [MD_WIDTH-1:0] data_result,
    output logic                data_exception,
    output logic                data_resultRDY
);

    md_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*MD_WIDTH-1:0]   acc_q, acc_d;
    logic [MD_WIDTH-1:0]     opnd_q, opnd_d;
    logic [MD_WIDTH:0]       rem_q, rem_d;
    logic [MD_WIDTH-1:0]     quo_q, quo_d;
    logic                    neg_q, neg_d;
    logic                    div_q, div_d;
    logic                    dbz_q, dbz_d;
    logic                    ovf_q, ovf_d;
    logic [MD_WIDTH-1:0]     result_q, result_d;
    logic                    exc_q, exc_d;
    logic                    rdy_q, rdy_d;

    logic [MD_WIDTH-1:0]     w_abs_a;
    logic [MD_WIDTH-1:0]     w_abs_b;
    logic                    w_b_zero;
    logic                    w_sign;
    logic                    w_last;
    logic [MD_WIDTH:0]       w_mult_sum;
    logic [2*MD_WIDTH-1:0]   w_acc_step;
    logic [2*MD_WIDTH-1:0]   w_prod;
    logic                    w_mult_exc;
    logic [MD_WIDTH-1:0]     w_quo_signed;
    logic [MD_WIDTH:0]       w_rem_step;
    logic [MD_WIDTH-1:0]     w_quo_step;

    assign w_abs_a  = abs_val(data_operandA);
    assign w_abs_b  = abs_val(data_operandB);
    assign w_b_zero = (data_operandB == '0);
    assign w_sign   = data_operandA[MD_WIDTH-1] ^ data_operandB[MD_WIDTH-1];
    assign w_last   = (cnt_q == CNT_W'(MD_ITERS - 1));

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_mult_sum = {1'b0, acc_q[2*MD_WIDTH-1:MD_WIDTH]} + {1'b0, opnd_q};
    assign w_acc_step = acc_q[0] ? {w_mult_sum, acc_q[MD_WIDTH-1:1]}
                                 : {1'b0, acc_q[2*MD_WIDTH-1:1]};

    assign w_prod       = neg_q ? -acc_q : acc_q;
    assign w_mult_exc   = (w_prod[2*MD_WIDTH-1:MD_WIDTH] != {MD_WIDTH{w_prod[MD_WIDTH-1]}});
    assign w_quo_signed = neg_q ? -quo_q : quo_q;

    multdiv_div_step u_div_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (opnd_q),
        .rem_o     (w_rem_step),
        .quo_o     (w_quo_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        neg_d    = neg_q;
        div_d    = div_q;
        dbz_d    = dbz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        // A start pulse in any state restarts; the abandoned operation never reports.
        if (ctrl_mult) begin
            state_d  = MULT;
            cnt_d    = '0;
            opnd_d   = w_abs_a;
            acc_d    = {{MD_WIDTH{1'b0}}, w_abs_b};
            neg_d    = w_sign;
            div_d    = 1'b0;
            dbz_d    = 1'b0;
            ovf_d    = 1'b0;
            result_d = '0;
            exc_d    = 1'b0;
        end else if (ctrl_div) begin
            state_d  = DIV;
            cnt_d    = '0;
            opnd_d   = w_abs_b;
            quo_d    = w_abs_a;
            rem_d    = '0;
            neg_d    = w_sign;
            div_d    = 1'b1;
            dbz_d    = w_b_zero;
            ovf_d    = (data_operandA == INT_MIN) && (data_operandB == '1);
            result_d = '0;
            exc_d    = 1'b0;
`ifdef MULTDIV_DBZ_FAST_EN
            if (w_b_zero) begin
                state_d = DONE;
            end
`endif
        end else begin
            case (state_q)
                MULT: begin
                    acc_d = w_acc_step;
                    if (w_last) state_d = DONE;
                    else        cnt_d   = cnt_q + CNT_W'(1);
                end
                DIV: begin
                    rem_d = w_rem_step;
                    quo_d = w_quo_step;
                    if (w_last) state_d = DONE;
                    else        cnt_d   = cnt_q + CNT_W'(1);
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rdy_d   = 1'b1;
                    if (!div_q) begin
                        result_d = w_prod[MD_WIDTH-1:0];
                        exc_d    = w_mult_exc;
                    end else if (dbz_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (ovf_q) begin
                        result_d = INT_MIN;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = w_quo_signed;
                        exc_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            neg_q    <= 1'b0;
            div_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            neg_q    <= neg_d;
            div_q    <= div_d;
            dbz_q    <= dbz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_unit
// Brief    : Self-checking bench for multdiv_unit (honours MULTDIV_DBZ_FAST_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_unit;

`ifdef MULTDIV_DBZ_FAST_EN
    localparam int DBZ_LAT = 1;
`else
    localparam int DBZ_LAT = 33;
`endif
    localparam int OP_LAT = 33;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        longint      due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    exp_t        sb[$];
    exp_t        mon_e;
    longint      cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        prev_rdy = 1'b0;
    logic [31:0] last_res;
    logic        last_exc;

    multdiv_unit dut (
        .clk            (clk),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_mult      (ctrl_mult),
        .ctrl_div       (ctrl_div),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from native signed arithmetic.
    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'h0) begin
            r = 32'h0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    // Pulse a start for one edge, then scramble operands to show they are not re-sampled.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                            input bit push);
        exp_t x;
        @(negedge clk);
        ctrl_mult     = m;
        ctrl_div      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clk);
        #1;
        ctrl_mult     = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check("clear_on_start_result", data_result, 0);
        check("clear_on_start_exc", data_exception, 0);
        if (push) begin
            model(m, a, b, x.res, x.exc);
            x.due    = cyc + ((!m && b == 32'h0) ? DBZ_LAT : OP_LAT);
            last_res = x.res;
            last_exc = x.exc;
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        start_op(m, d, a, b, 1'b1);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("hold_result", data_result, last_res);
        check("hold_exc", data_exception, last_exc);
        check("hold_rdy_low", data_resultRDY, 0);
    endtask

    // Every ready pulse must match the oldest outstanding expectation, on its cycle.
    always @(posedge clk) begin
        #1;
        if (data_resultRDY) begin
            check("rdy_not_back_to_back", prev_rdy, 0);
            check("rdy_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("rdy_cycle", cyc, mon_e.due);
                check("result", data_result, mon_e.res);
                check("exception", data_exception, mon_e.exc);
            end
        end
        prev_rdy = data_resultRDY;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int  hi;
        bit  m;
        reset         = 1'b1;
        ctrl_mult     = 1'b0;
        ctrl_div      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", data_result, 0);
        check("reset_exc", data_exception, 0);
        check("reset_rdy", data_resultRDY, 0);
        @(negedge clk);
        reset = 1'b0;

        hi = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) hi++;
        end
        check("idle_no_rdy", hi, 0);

        run_op(1, 0, 32'd7, 32'hFFFF_FFFD);
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000);
        run_op(0, 1, 32'hFFFF_FFEF, 32'd5);
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(0, 1, 32'd10, 32'd0);
        run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(1, 1, 32'hFFFF_FFFA, 32'd7);
        run_op(0, 1, 32'd7, 32'hFFFF_FFFE);
        run_op(0, 1, 32'd0, 32'd5);
        run_op(0, 1, 32'h8000_0000, 32'd1);
        for (int i = 0; i < 6; i++) begin
            m = 1'(i % 2);
            run_op(m, !m, $urandom, $urandom >> $urandom_range(0, 31));
        end

        // New start sampled in the ready cycle of the previous op.
        start_op(1, 0, 32'd123, 32'd456, 1'b1);
        repeat (OP_LAT) @(posedge clk);
        start_op(0, 1, 32'd1000, 32'hFFFF_FFF9, 1'b1);
        drain();

        // Divide aborted ten cycles in by a multiply.
        start_op(0, 1, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        start_op(1, 0, 32'd6, 32'd7, 1'b1);
        drain();

        // Multiply aborted while in its final (DONE) cycle.
        start_op(1, 0, 32'd5, 32'd5, 1'b0);
        repeat (OP_LAT - 1) @(posedge clk);
        start_op(0, 1, 32'd99, 32'd4, 1'b1);
        drain();

        // Reset five cycles into a divide.
        start_op(0, 1, 32'd100, 32'd7, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_result", data_result, 0);
        check("midreset_exc", data_exception, 0);
        check("midreset_rdy", data_resultRDY, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (45) @(posedge clk);

        // Reset coincident with a start pulse: nothing starts.
        @(negedge clk);
        reset         = 1'b1;
        ctrl_mult     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(posedge clk);
        #1;
        ctrl_mult = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        hi = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) hi++;
        end
        check("reset_beats_start", hi, 0);

        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
